// File: rtl/key_debounce.sv
// key_debounce
//
// Input conditioning for two active-low push-buttons. Each button is
// synchronised, debounced by a stability counter and then tracked by a hold
// counter. The clean level drives the LED control logic. The one-cycle event
// pulses go to any other consumer.
//
// Parameters:
//   DEBOUNCE_CNT  consecutive stable cycles before a new level is accepted
//   LONG_CNT      cycles key_out must stay low before a long-press event
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   key_in       in   [1:0] raw button pins, active-low, asynchronous
//   key_out      out  [1:0] debounced level, active-low (2'b11 = idle)
//   key_press    out  [1:0] one-cycle pulse when key_out[i] goes 1->0
//   key_release  out  [1:0] one-cycle pulse when key_out[i] goes 0->1
//   key_long     out  [1:0] one-cycle pulse when key_out[i] has been low LONG_CNT cycles
//
// The two keys share no state. All per-key logic is written once and is
// unrolled over the key index.

module key_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 20'd1000000,
    parameter int unsigned LONG_CNT     = 26'd50000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] key_in,
    output logic [1:0] key_out,
    output logic [1:0] key_press,
    output logic [1:0] key_release,
    output logic [1:0] key_long
);

    localparam int unsigned NumKeys = 2;

    // Counter widths are sized to hold the terminal value (COUNT-1) exactly.
    localparam int unsigned DbW   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int unsigned HoldW = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;

    localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CNT - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CNT - 1);
    localparam logic [HoldW-1:0] HoldPre = HoldW'(LONG_CNT - 2);

    // Two-stage synchroniser. Both stages reset high, which is the idle level.
    logic [NumKeys-1:0] key_meta_q;
    logic [NumKeys-1:0] key_sync_q;

    logic [NumKeys-1:0] key_out_q,     key_out_d;
    logic [NumKeys-1:0] key_press_q,   key_press_d;
    logic [NumKeys-1:0] key_release_q, key_release_d;
    logic [NumKeys-1:0] key_long_q,    key_long_d;

    logic [DbW-1:0]   db_cnt_q   [NumKeys];
    logic [DbW-1:0]   db_cnt_d   [NumKeys];
    logic [HoldW-1:0] hold_cnt_q [NumKeys];
    logic [HoldW-1:0] hold_cnt_d [NumKeys];

    //--------------------------------------------------------------------
    // Synchroniser
    //--------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
        end else begin
            key_meta_q <= key_in;
            key_sync_q <= key_meta_q;
        end
    end

    //--------------------------------------------------------------------
    // Debounce, event and hold next-state logic
    //--------------------------------------------------------------------
    always_comb begin
        key_out_d     = key_out_q;
        key_press_d   = '0;
        key_release_d = '0;
        key_long_d    = '0;
        for (int i = 0; i < NumKeys; i++) begin
            db_cnt_d[i]   = '0;
            hold_cnt_d[i] = '0;
        end

        for (int i = 0; i < NumKeys; i++) begin
            // Count only an uninterrupted disagreement. Any agreeing cycle
            // restarts the filter through the default clear above.
            if (key_sync_q[i] != key_out_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    key_out_d[i]     = key_sync_q[i];
                    key_press_d[i]   = ~key_sync_q[i];
                    key_release_d[i] = key_sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end

            // The hold counter follows the registered level. It starts
            // counting on the edge after the fall and saturates. The long
            // pulse therefore fires exactly once per press.
            if (!key_out_q[i]) begin
                if (hold_cnt_q[i] != HoldMax) begin
                    hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                end else begin
                    hold_cnt_d[i] = hold_cnt_q[i];
                end
                key_long_d[i] = (hold_cnt_q[i] == HoldPre);
            end
        end
    end

    //--------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_out_q     <= '1;
            key_press_q   <= '0;
            key_release_q <= '0;
            key_long_q    <= '0;
            for (int i = 0; i < NumKeys; i++) begin
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            key_out_q     <= key_out_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            key_long_q    <= key_long_d;
            for (int i = 0; i < NumKeys; i++) begin
                db_cnt_q[i]   <= db_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign key_out     = key_out_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign key_long    = key_long_q;

endmodule

// File: doc/key_debounce.md
# key_debounce

Input conditioning stage for the two active-low push-buttons. It synchronises the raw `key` pins, filters contact bounce with a per-key stability counter, and drives a clean debounced level bus. That bus is the `key` input of the LED control logic. It also produces one-cycle press, release and long-press event pulses for other consumers.

## Interface
Parameters:
- `DEBOUNCE_CNT`, default 20'd1000000: consecutive stable cycles required to accept a new key level (20 ms at 50 MHz).
- `LONG_CNT`, default 26'd50000000: cycles `key_out` must stay low before a long-press event (1 s at 50 MHz).

Ports:
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `key_in`  in  2  raw button pins, active-low (0 = pressed), asynchronous to `sys_clk`.
- `key_out`  out  2  debounced level, active-low; 2'b11 = no key pressed.
- `key_press`  out  2  one-cycle pulse per bit when `key_out[i]` goes 1→0.
- `key_release`  out  2  one-cycle pulse per bit when `key_out[i]` goes 0→1.
- `key_long`  out  2  one-cycle pulse per bit when `key_out[i]` has been 0 for `LONG_CNT` cycles.

## Operation
- Both bits are fully independent: separate synchroniser, debounce counter and hold counter per key.
- Synchroniser: two flip-flops per bit, both reset to 1. The second stage is `key_sync[i]`.
- Debounce counter `db_cnt[i]`:
  - Width holds `DEBOUNCE_CNT-1`.
  - Each cycle where `key_sync[i] != key_out[i]`, it increments.
  - Any cycle where `key_sync[i] == key_out[i]`, it clears to 0. A single glitch cycle restarts the filter.
  - When `key_sync[i] != key_out[i]` and `db_cnt[i] == DEBOUNCE_CNT-1`, then on that edge `key_out[i] <= key_sync[i]` and `db_cnt[i] <= 0`.
- Event pulses are registered on the same edge as the `key_out` change:
  - `key_press[i]` = 1 on a 1→0 change.
  - `key_release[i]` = 1 on a 0→1 change.
  - Both are 0 in every other cycle.
- Hold counter `hold_cnt[i]`:
  - Width holds `LONG_CNT-1`.
  - While `key_out[i] == 0`, it increments up to `LONG_CNT-1` and saturates there.
  - While `key_out[i] == 1`, it is held at 0.
  - `key_long[i]` pulses for one cycle on the edge where `hold_cnt[i]` goes from `LONG_CNT-2` to `LONG_CNT-1`. This gives at most one long pulse per press. There is no auto-repeat.
- Simultaneous events on both keys produce pulses on both bits in the same cycle.
- A release before `LONG_CNT` clears `hold_cnt`; no `key_long` pulse is produced for that press.

## Timing
- Reset values:
  - `key_out` = 2'b11.
  - `key_press`, `key_release`, `key_long` = 2'b00.
  - Synchronisers = 2'b11.
  - All counters = 0.
- Reset takes effect asynchronously on assertion; release is sampled on `sys_clk`.
- Latency: a pin change first sampled at edge 1 (and stable afterwards) appears on `key_out` after edge `DEBOUNCE_CNT+2`.
  - 2 cycles of synchroniser, then `DEBOUNCE_CNT` counting edges.
  - The matching press/release pulse is high during the cycle after that edge.
- Minimum accepted pulse width on a pin is `DEBOUNCE_CNT` cycles. Shorter excursions produce no output change and no event.
- `key_long` occurs `LONG_CNT-1` edges after the edge that pulled `key_out[i]` low.
- Reset mid-operation: all state returns to reset values immediately and no pulse is emitted. A key still held when reset releases is treated as a new press: `key_press` fires `DEBOUNCE_CNT+2` cycles later.
- Counters never wrap: `db_cnt` clears on acceptance, and `hold_cnt` saturates.

## Test plan
Run with `DEBOUNCE_CNT`=10 and `LONG_CNT`=50.

1. **Clean press:** `key_in` 11→10 at edge 1, then held. Required: `key_out` = 10 after edge 12; `key_press` = 01 for exactly one cycle; `key_release` and `key_long` stay 00.
2. **Bounce:** `key_in[0]` toggles every 3 cycles for 30 cycles, then settles at 0. Required: exactly one `key_press[0]` pulse; `key_out[0]` falls 12 edges after the last toggle; no spurious `key_release`.
3. **Glitch reject:** `key_in[1]` low for 9 cycles, then high. Required: `key_out` stays 11; all pulse outputs stay 00.
4. **Long press:** `key_in[0]` low for 100 cycles, then high. Required:
   - `key_long` = 01 for one cycle, 49 edges after the `key_out[0]` fall edge;
   - no second `key_long`;
   - `key_release[0]` pulse 12 edges after release.
5. **Simultaneous keys:** both `key_in` bits fall on the same edge. Required: `key_out` goes 11→00 in one step; `key_press` = 11 for one cycle. Releasing both together gives `key_release` = 11 for one cycle.
6. **Reset mid-hold:** assert `sys_rst_n` = 0 while `key_out` = 10 and `hold_cnt[0]` = 30, keeping `key_in` = 10. Required:
   - outputs go to 11/00/00/00 immediately (asynchronously);
   - after reset release, `key_press` = 01 fires 12 cycles later;
   - `key_long` arrives a full 49 edges after that fall.
